nascom_cassette_tx: RTL
=======================

NASCOM_CASSETTE_TX -- requirements
Module: nascom_cassette_tx

Interface
REQ-001 SHALL have parameter HALF_2400, default 833, meaning clk cycles per half-period of the 2400 Hz tone (legal range 2..4095).
REQ-002 SHALL have parameter STOP_BITS, default 2, meaning stop bits per character (legal 1 or 2).
REQ-003 SHALL have port clk, input, 1, the single clock; all logic is rising-edge clk.
REQ-004 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-005 SHALL have port en, input, 1, cassette write enable (motor/record on).
REQ-006 SHALL have port tx_data, input, 8, byte to transmit.
REQ-007 SHALL have port tx_valid, input, 1, tx_data valid.
REQ-008 SHALL have port tx_ready, output, 1, byte accepted on a cycle where tx_valid and tx_ready are both 1.
REQ-009 SHALL have port busy, output, 1, character pending or in transmission.
REQ-010 SHALL have port tone_out, output, 1, Kansas City FSK square wave toward the cassette output stage.

Function
REQ-011 SHALL generate a half-period tick every HALF_2400 clk cycles (counter half_cnt, 0..HALF_2400-1), and count 16 ticks per bit (sub_cnt, 0..15); a bit boundary is the tick with sub_cnt=15.
REQ-012 SHALL toggle tone_out on every tick for a '1'/mark bit (8 cycles of 2400 Hz) and on ticks with sub_cnt odd for a '0'/space bit (4 cycles of 1200 Hz); bit time = 16*HALF_2400 clk.
REQ-013 SHALL change the current bit value only at a bit boundary, so tone_out is phase-continuous and starts every bit at level 0.
REQ-014 SHALL implement states IDLE (mark), START (space), DATA (8 bits, LSB first, bit index 0..7), STOP (mark, STOP_BITS bits).
REQ-015 SHALL drive tx_ready=1 only when en=1, state=IDLE and no byte is pending.
REQ-016 SHALL latch tx_data into a shift register and set pending on acceptance; pending SHALL clear when START is entered.
REQ-017 SHALL move IDLE->START at the first bit boundary where pending=1, including acceptance in the cycle immediately before that boundary; acceptance in the boundary cycle itself SHALL start at the following boundary.
REQ-018 SHALL move START->DATA, DATA(bit 7)->STOP, STOP(last stop bit)->IDLE, each at a bit boundary.
REQ-019 SHALL assert busy when pending=1 or state!=IDLE.
REQ-020 SHALL, while en=0, hold state IDLE, half_cnt=0, sub_cnt=0, tone_out=0, pending=0, tx_ready=0; any character in progress is dropped without completion.
REQ-021 SHALL resume on en 0->1 with half_cnt=0, sub_cnt=0, sending mark from IDLE.
REQ-022 SHALL ignore tx_data changes after acceptance and ignore tx_valid while tx_ready=0.

Reset
REQ-023 SHALL, on rst=1 at a clk edge, set state IDLE, half_cnt=0, sub_cnt=0, bit index=0, pending=0, shift register=0x00, tone_out=0; rst takes priority over en and tx_valid.
REQ-024 SHALL, during and after reset until the first edge with rst=0, present tx_ready=0, busy=0, tone_out=0; tx_ready follows REQ-015 after reset, aborting any character mid-operation.

Verification (HALF_2400=4, STOP_BITS=2, bit time 64 clk)
REQ-025 SHALL verify idle: rst then en=1, no tx_valid -> tone_out toggles every 4 clk, tx_ready=1, busy=0.
REQ-026 SHALL verify byte 0xA5: accepted at cycle t -> START at next boundary; 11 bits follow; tone half-periods per bit in order 8,4,8,4,8,8,4,8,4,4,4 clk (space, then data 1,0,1,0,0,1,0,1, then mark, mark) -> then idle mark, tx_ready=1.
REQ-027 SHALL verify timing: acceptance in boundary cycle -> exactly one full 64-clk mark bit before START; acceptance one cycle before boundary -> START at that boundary.
REQ-028 SHALL verify back-to-back 0x00 then 0xFF -> tx_ready=0 from acceptance to end of second stop bit; second START is not earlier than the boundary following re-acceptance.
REQ-029 SHALL verify abort: en=0 in DATA bit 3 -> next cycle tone_out=0, busy=0, tx_ready=0; en=1 -> mark with no residual data bits.
REQ-030 SHALL verify reset mid-character: rst=1 during STOP -> all outputs reset per REQ-023/024 the following cycle; no stop-bit tail.

Source files
------------

// File: rtl/nascom_cassette_tx.sv
// Kansas City FSK cassette transmitter: serialises bytes as start/data/stop
// bits, mark = 8 cycles of 2400 Hz, space = 4 cycles of 1200 Hz.
// Ports:
//   clk      - single rising-edge clock
//   rst      - synchronous active-high reset
//   en       - cassette write enable (motor/record on)
//   tx_data  - byte to transmit, taken when tx_valid && tx_ready
//   tx_valid - tx_data valid
//   tx_ready - a byte can be accepted this cycle
//   busy     - a character is pending or in transmission
//   tone_out - FSK square wave toward the cassette output stage
module nascom_cassette_tx #(
    parameter int HALF_2400 = 833,
    parameter int STOP_BITS = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       busy,
    output logic       tone_out
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic [1:0]  state;
    logic [11:0] half_cnt;
    logic [3:0]  sub_cnt;
    logic [2:0]  bit_idx;
    logic        stop_cnt;
    logic        pending;
    logic [7:0]  shreg;

    logic tick;
    logic boundary;
    logic cur_bit;
    logic accept;

    assign tick     = (half_cnt == 12'(HALF_2400 - 1));
    assign boundary = tick && (sub_cnt == 4'd15);

    // Bit currently on the line; state only moves at a bit boundary, so
    // this value is stable for a whole bit time.
    always_comb begin
        cur_bit = 1'b1;
        case (state)
            S_IDLE:  cur_bit = 1'b1;
            S_START: cur_bit = 1'b0;
            S_DATA:  cur_bit = shreg[0];
            S_STOP:  cur_bit = 1'b1;
            default: cur_bit = 1'b1;
        endcase
    end

    // Gated by rst so the outputs read idle/quiet while reset is held.
    assign tx_ready = en && !rst && (state == S_IDLE) && !pending;
    assign busy     = !rst && (pending || (state != S_IDLE));
    assign accept   = tx_valid && tx_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            half_cnt <= '0;
            sub_cnt  <= '0;
            bit_idx  <= '0;
            stop_cnt <= 1'b0;
            pending  <= 1'b0;
            shreg    <= '0;
            tone_out <= 1'b0;
        end else if (!en) begin
            // Motor off: drop anything in flight and park the tone low.
            state    <= S_IDLE;
            half_cnt <= '0;
            sub_cnt  <= '0;
            bit_idx  <= '0;
            stop_cnt <= 1'b0;
            pending  <= 1'b0;
            tone_out <= 1'b0;
        end else begin
            half_cnt <= tick ? '0 : half_cnt + 12'd1;

            if (tick) begin
                sub_cnt <= sub_cnt + 4'd1;
                // Mark toggles every tick, space every other tick; both
                // give an even toggle count per bit, so each bit starts low.
                if (cur_bit || sub_cnt[0])
                    tone_out <= ~tone_out;
            end

            if (accept) begin
                shreg   <= tx_data;
                pending <= 1'b1;
            end

            if (boundary) begin
                case (state)
                    S_IDLE: begin
                        if (pending) begin
                            state   <= S_START;
                            pending <= 1'b0;
                        end
                    end
                    S_START: begin
                        state   <= S_DATA;
                        bit_idx <= '0;
                    end
                    S_DATA: begin
                        shreg   <= {1'b0, shreg[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
                            state    <= S_STOP;
                            stop_cnt <= 1'b0;
                        end
                    end
                    S_STOP: begin
                        if (stop_cnt == 1'(STOP_BITS - 1))
                            state <= S_IDLE;
                        else
                            stop_cnt <= stop_cnt + 1'b1;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule
